// File: rtl/audipus_spi_pkg.sv
// Shared definitions for the audipus 16-bit SPI register-access frame.
// Imported by the SPI register master and by the slave-side register file.
//   - register address map (audio control through MPIO-to-SPI bridge)
//   - frame geometry and R/W encoding
//   - master FSM state encoding
//   - build_frame(): packs a register command into the on-wire frame
package audipus_spi_pkg;

  // Register address map
  localparam logic [6:0] REG_AUDIO_CTRL   = 7'h00;
  localparam logic [6:0] REG_AUDIO_STATUS = 7'h01;
  localparam logic [6:0] REG_CLK_CFG      = 7'h02;
  localparam logic [6:0] REG_I2S_CFG      = 7'h03;
  localparam logic [6:0] REG_VOL_LEFT     = 7'h04;
  localparam logic [6:0] REG_VOL_RIGHT    = 7'h05;
  localparam logic [6:0] REG_MIX_CFG      = 7'h06;
  localparam logic [6:0] REG_GPIO_DIR     = 7'h07;
  localparam logic [6:0] REG_GPIO_OUT     = 7'h08;
  localparam logic [6:0] REG_GPIO_IN      = 7'h09;
  localparam logic [6:0] REG_IRQ_MASK     = 7'h0a;
  localparam logic [6:0] REG_IRQ_STATUS   = 7'h0b;
  localparam logic [6:0] REG_MPIO_CFG     = 7'h0c;
  localparam logic [6:0] REG_MPIO_SPI     = 7'h0d;

  // Frame geometry: {rw, addr[6:0], data[7:0]}, MSB first on the wire
  localparam int         FRAME_W  = 16;
  localparam int         RW_BIT   = 15;
  localparam logic       RW_WRITE = 1'b1;
  localparam logic       RW_READ  = 1'b0;

  // Master FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CS_HOLD = 2'd2,
    ST_GAP     = 2'd3
  } spi_state_e;

  // Reads carry a zero data byte so the slave sees a deterministic MOSI stream.
  function automatic logic [FRAME_W-1:0] build_frame(input logic       wr,
                                                     input logic [6:0] addr,
                                                     input logic [7:0] wdata);
    logic [7:0] data_byte;
    data_byte = (wr == RW_WRITE) ? wdata : 8'h00;
    return {wr, addr, data_byte};
  endfunction

endpackage

// File: rtl/spi_reg_master_if.sv
// Command/response bus of the SPI register master.
//   master modport : command requester (drives cmd_*, receives rsp_*/busy)
//   slave modport  : spi_reg_master itself
interface spi_reg_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/spi_reg_master_sclk_timer.sv
// Half-period timer for the SPI register master.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   en         : run the timer; when low the counter and phase are held at zero
//   phase_end  : last cycle of the current CLK_DIV-cycle half period
//   rise       : phase_end of a low half period (spi_clk goes high next)
//   fall       : phase_end of a high half period (spi_clk goes low next)
module spi_sclk_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic phase_end,
  output logic rise,
  output logic fall
);
  localparam int             CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             level_r;

  assign phase_end = en && (cnt_r == LAST);
  assign rise      = phase_end && !level_r;
  assign fall      = phase_end && level_r;

  // Half-period counter and the low/high phase it is currently timing
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else if (!en) begin
      cnt_r   <= '0;
      level_r <= 1'b0;
    end else if (cnt_r == LAST) begin
      cnt_r   <= '0;
      level_r <= ~level_r;
    end else begin
      cnt_r   <= cnt_r + CNT_W'(1);
    end
  end
endmodule

// File: rtl/spi_reg_master.sv
// SPI mode-0 master for the 16-bit register-access frame (command byte,
// then data byte). One command is taken on the valid/ready bus, shifted out
// MSB first, and the MISO byte seen during the data byte is returned with a
// one-cycle rsp_valid pulse.
// Ports:
//   clk, reset        : system clock, synchronous active-high reset
//   bus (slave)       : cmd_valid/ready/write/addr/wdata, rsp_valid/rdata, busy
//   spi_cs0           : chip select, active low
//   spi_clk, spi_mosi : SPI clock (idle low) and serial data out
//   spi_miso          : serial data in
// Frame timeline (C = CLK_DIV, acceptance cycle = 0): SHIFT 1..32C,
// CS_HOLD 32C+1..33C, GAP 33C+1..34C with rsp_valid on 33C+1, ready on 34C+1.
module spi_reg_master
  import audipus_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic            clk,
  input  logic            reset,
  spi_reg_master_if.slave bus,
  output logic            spi_cs0,
  output logic            spi_clk,
  output logic            spi_mosi,
  input  logic            spi_miso
);
  spi_state_e         state_r, state_n;
  logic [FRAME_W-1:0] shift_r, shift_n;
  logic [FRAME_W-1:0] frame_s;
  logic [3:0]         bit_cnt_r, bit_cnt_n;
  logic               cs0_r, cs0_n;
  logic               sclk_r, sclk_n;
  logic               mosi_r, mosi_n;
  logic               ready_r, ready_n;
  logic               busy_r, busy_n;
  logic               rsp_valid_r, rsp_valid_n;
  logic [7:0]         rdata_r, rdata_n;
  logic               accept_s;
  logic               timer_en_s;
  logic               phase_end_s;
  logic               rise_s;
  logic               fall_s;

  assign frame_s    = build_frame(bus.cmd_write, bus.cmd_addr, bus.cmd_wdata);
  // ready_r is only ever set in IDLE, so it doubles as the IDLE qualifier
  assign accept_s   = bus.cmd_valid && ready_r;
  assign timer_en_s = (state_r != ST_IDLE);

  spi_sclk_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .en        (timer_en_s),
    .phase_end (phase_end_s),
    .rise      (rise_s),
    .fall      (fall_s)
  );

  // State and output registers; reset forces the idle line state and drops any frame
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      shift_r     <= '0;
      bit_cnt_r   <= 4'd0;
      cs0_r       <= 1'b1;
      sclk_r      <= 1'b0;
      mosi_r      <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rdata_r     <= 8'h00;
    end else begin
      state_r     <= state_n;
      shift_r     <= shift_n;
      bit_cnt_r   <= bit_cnt_n;
      cs0_r       <= cs0_n;
      sclk_r      <= sclk_n;
      mosi_r      <= mosi_n;
      ready_r     <= ready_n;
      busy_r      <= busy_n;
      rsp_valid_r <= rsp_valid_n;
      rdata_r     <= rdata_n;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  always_comb begin
    state_n     = state_r;
    shift_n     = shift_r;
    bit_cnt_n   = bit_cnt_r;
    cs0_n       = cs0_r;
    sclk_n      = sclk_r;
    mosi_n      = mosi_r;
    ready_n     = ready_r;
    busy_n      = busy_r;
    rsp_valid_n = 1'b0;
    rdata_n     = rdata_r;

    case (state_r)
      ST_IDLE: begin
        ready_n = 1'b1;
        if (accept_s) begin
          state_n   = ST_SHIFT;
          shift_n   = frame_s;
          bit_cnt_n = 4'd15;
          cs0_n     = 1'b0;
          sclk_n    = 1'b0;
          mosi_n    = frame_s[RW_BIT];
          ready_n   = 1'b0;
          busy_n    = 1'b1;
        end else begin
          state_n   = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        if (rise_s) begin
          sclk_n = 1'b1;
        end else if (fall_s) begin
          // MISO is sampled on the last high cycle; after 16 shifts the low
          // byte of the shift register holds the data-byte samples.
          sclk_n  = 1'b0;
          shift_n = {shift_r[FRAME_W-2:0], spi_miso};
          if (bit_cnt_r == 4'd0) begin
            state_n = ST_CS_HOLD;
            mosi_n  = 1'b0;
          end else begin
            bit_cnt_n = bit_cnt_r - 4'd1;
            mosi_n    = shift_r[FRAME_W-2];
          end
        end else begin
          sclk_n = sclk_r;
        end
      end

      ST_CS_HOLD: begin
        if (phase_end_s) begin
          state_n     = ST_GAP;
          cs0_n       = 1'b1;
          rsp_valid_n = 1'b1;
          rdata_n     = shift_r[7:0];
        end else begin
          state_n     = ST_CS_HOLD;
        end
      end

      ST_GAP: begin
        if (phase_end_s) begin
          state_n = ST_IDLE;
          ready_n = 1'b1;
          busy_n  = 1'b0;
        end else begin
          state_n = ST_GAP;
        end
      end

      default: begin
        state_n = ST_IDLE;
        cs0_n   = 1'b1;
        sclk_n  = 1'b0;
        mosi_n  = 1'b0;
        ready_n = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign spi_cs0       = cs0_r;
  assign spi_clk       = sclk_r;
  assign spi_mosi      = mosi_r;
  assign bus.cmd_ready = ready_r;
  assign bus.busy      = busy_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rdata_r;
endmodule
